dpa_photo_sequencer: RTL and testbench
======================================

# dpa_photo_sequencer

Parametrised slideshow engine for the digital photo album. It loads a photo header from image memory and copies each photo into the frame buffer in turn, holding each one for a programmable number of seconds. Each photo after the first can be drawn either as a direct copy or as a two-pass interlaced transition. It owns the single-port image memory bus while busy; time-of-day rendering is a separate block.

## Interface
- ADDR_W, 20, image memory address width
- DATA_W, 24, image memory word width
- MAX_PHOTOS, 4, maximum photo slots read from header (1..16)
- IMG_W, 128, pixels per row
- IMG_H, 128, rows per photo
- TICKS_PER_SEC, 1000000, clk cycles per second (1 MHz clk)
- HOLD_SEC, 1, seconds each photo is held after it is drawn
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- stop  in  1  one-cycle pulse; sets a sticky stop request
- trans_mode  in  1  0 = direct copy, 1 = interlaced; sampled at start of each copy
- IM_A  out  ADDR_W  image memory address
- IM_Q  in  DATA_W  image memory read data, valid the cycle after the address
- IM_D  out  DATA_W  image memory write data
- IM_WEN  out  1  1 = read, 0 = write
- busy  out  1  high in every state except IDLE
- photo_idx  out  4  index of the photo being drawn or shown
- frame_done  out  1  one-cycle pulse when a photo copy completes

## Operation
- Header layout (word addresses):
  - 0 = fb_addr
  - 1 = photo_num
  - 2+i = base address of photo i, for i < MAX_PHOTOS
- Photo count n = photo_num[3:0], clamped:
  - 0 becomes 1
  - greater than MAX_PHOTOS becomes MAX_PHOTOS
- States:
  - IDLE: start -> HDR.
  - HDR: reads 2+MAX_PHOTOS consecutive words, one read per cycle, each captured one cycle later. After the last capture -> COPY with photo_idx=0.
  - COPY: handles one pixel per 2 cycles.
    - R cycle: IM_A = src, IM_WEN=1.
    - W cycle: IM_A = dst, IM_WEN=0, IM_D=IM_Q.
    - src = base[idx] + row*IMG_W + col; dst = fb_addr + row*IMG_W + col.
    - Address arithmetic wraps modulo 2^ADDR_W.
    - Direct mode visits rows 0..IMG_H-1 in order.
    - Interlaced mode visits even rows ascending, then odd rows ascending.
    - Photo 0 after HDR is always drawn direct.
    - After the last W cycle -> WAIT and pulse frame_done.
  - WAIT: runs a second counter (TICKS_PER_SEC) and a hold counter (HOLD_SEC).
    - On expiry with no stop request: photo_idx = (idx == n-1) ? 0 : idx+1, then -> COPY.
    - On expiry with a stop request: -> IDLE.
- stop is never acted on mid-copy. A pending stop ends the sequence at the next WAIT expiry and is cleared on entering IDLE.
- start while busy is ignored. stop and start in the same IDLE cycle: start wins and stop is discarded.
- n=1 redraws photo 0 each period, honouring trans_mode.

## Timing
- Reset values:
  - IM_A=0, IM_D=0, IM_WEN=1, busy=0, photo_idx=0, frame_done=0
  - all counters and header registers 0, state IDLE
- start sampled at cycle T; first header read at T+1; busy=1 from T+1.
- HDR lasts 3+MAX_PHOTOS cycles, including the final capture cycle.
- COPY lasts exactly 2*IMG_W*IMG_H cycles. The first R cycle is the cycle after HDR or WAIT ends.
- frame_done is high during the first WAIT cycle.
- WAIT lasts exactly HOLD_SEC*TICKS_PER_SEC cycles.
- IM_WEN=0 only in W cycles. IM_D holds its last value outside W cycles.
- In IDLE, IM_A=0 and IM_WEN=1.
- Reset asserted mid-copy returns every output to its reset value immediately. No further writes occur.

## Test plan
All scenarios use IMG_W=4, IMG_H=2, MAX_PHOTOS=4, TICKS_PER_SEC=5, HOLD_SEC=2.
- Header and direct copy:
  - Stimulus: header fb=0x100, num=2, bases 0x200/0x300; start.
  - Response: 6 header reads at addresses 0..5; 8 writes to 0x100..0x107 equal to 0x200..0x207; frame_done 16 cycles after COPY entry.
- Hold and wrap:
  - Stimulus: continue running.
  - Response: WAIT of 10 cycles; photo 1 drawn; after a further 10 cycles photo 0 redrawn (idx wraps 1->0).
- Interlaced order:
  - Stimulus: trans_mode=1 for photo 1.
  - Response: destination sequence 0x100..0x103, then 0x104..0x107; write data matches 0x300+offset.
- Count clamping:
  - Stimulus: photo_num=0, then photo_num=9.
  - Response: photo_num=0 shows photo 0 only; photo_num=9 cycles through idx 0..3.
- Stop and start handling:
  - Stimulus: stop during COPY; start while busy.
  - Response: copy completes, WAIT completes, then IDLE with busy=0; start while busy is ignored.
- Reset mid-operation:
  - Stimulus: reset pulled low during a W cycle.
  - Response: IM_WEN=1 and busy=0 asynchronously; no write after release without a new start.

Source files
------------

// File: rtl/dpa_photo_sequencer.sv
// Slideshow engine: reads a photo header, then copies each photo into the frame buffer and holds it.
// Latency: header 3+MAX_PHOTOS cycles, copy 2*IMG_W*IMG_H cycles, hold HOLD_SEC*TICKS_PER_SEC cycles.
// Backpressure: none; owns the single-port image memory while busy, stop only takes effect at a hold expiry.
module dpa_photo_sequencer #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 24,
    parameter int MAX_PHOTOS    = 4,
    parameter int IMG_W         = 128,
    parameter int IMG_H         = 128,
    parameter int TICKS_PER_SEC = 1000000,
    parameter int HOLD_SEC      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              trans_mode,
    output logic [ADDR_W-1:0] IM_A,
    input  logic [DATA_W-1:0] IM_Q,
    output logic [DATA_W-1:0] IM_D,
    output logic              IM_WEN,
    output logic              busy,
    output logic [3:0]        photo_idx,
    output logic              frame_done
);

    localparam int HC_W   = $clog2(MAX_PHOTOS + 3);
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HOLD_W = (HOLD_SEC > 1) ? $clog2(HOLD_SEC) : 1;

    localparam logic [HC_W-1:0]   HC_LAST   = HC_W'(MAX_PHOTOS + 2);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SEC - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_COPY, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [HC_W-1:0]     hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_W-1:0]   fb_q, fb_d;
    logic [3:0]          n_q, n_d;
    logic [ADDR_W-1:0]   base_q [MAX_PHOTOS];
    logic [ADDR_W-1:0]   base_d [MAX_PHOTOS];
    logic [3:0]          idx_q, idx_d;
    logic                mode_q, mode_d;
    logic                phase_q, phase_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROW_W-1:0]    rows_done_q, rows_done_d;
    logic [SEC_W-1:0]    sec_q, sec_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                stop_req_q, stop_req_d;
    logic [DATA_W-1:0]   im_d_q, im_d_d;
    logic                frame_done_q, frame_done_d;

    logic [3:0]          num_clamped;
    logic [ADDR_W-1:0]   src_base;
    logic [ROW_W-1:0]    next_row;
    logic [ADDR_W-1:0]   pix_off;

    // Photo count from the header word: 0 means one photo, anything above the slot count is capped.
    always_comb begin
        num_clamped = IM_Q[3:0];
        if (IM_Q[3:0] == 4'd0) begin
            num_clamped = 4'd1;
        end else if (32'(IM_Q[3:0]) > MAX_PHOTOS) begin
            num_clamped = 4'(MAX_PHOTOS);
        end
    end

    // Base address of the photo currently being drawn.
    always_comb begin
        src_base = '0;
        for (int i = 0; i < MAX_PHOTOS; i++) begin
            if (idx_q == 4'(i)) src_base = base_q[i];
        end
    end

    // Row after the current one: sequential for direct, evens then odds for interlaced.
    always_comb begin
        next_row = row_q + ROW_W'(1);
        if (mode_q) begin
            if (32'(row_q) + 32'd2 >= 32'(IMG_H)) next_row = ROW_W'(1);
            else                                  next_row = row_q + ROW_W'(2);
        end
    end

    assign pix_off = ADDR_W'(row_q) * IMG_W_A + ADDR_W'(col_q);

    // Sequencer next state and memory bus drive.
    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        fb_d         = fb_q;
        n_d          = n_q;
        base_d       = base_q;
        idx_d        = idx_q;
        mode_d       = mode_q;
        phase_d      = phase_q;
        col_d        = col_q;
        row_d        = row_q;
        rows_done_d  = rows_done_q;
        sec_d        = sec_q;
        hold_d       = hold_q;
        stop_req_d   = stop_req_q;
        im_d_d       = im_d_q;
        frame_done_d = 1'b0;
        IM_A         = '0;
        IM_WEN       = 1'b1;
        IM_D         = im_d_q;

        // Stop is only remembered while running; the case below clears it when returning to idle.
        if (stop && state_q != S_IDLE) stop_req_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HDR;
                    hdr_cnt_d  = '0;
                    idx_d      = 4'd0;
                    stop_req_d = 1'b0;
                end
            end
            S_HDR: begin
                // Word k is addressed at count k and captured at count k+1.
                if (hdr_cnt_q != HC_LAST) IM_A = ADDR_W'(hdr_cnt_q);
                if (hdr_cnt_q == HC_W'(1)) fb_d = IM_Q[ADDR_W-1:0];
                if (hdr_cnt_q == HC_W'(2)) n_d = num_clamped;
                for (int i = 0; i < MAX_PHOTOS; i++) begin
                    if (hdr_cnt_q == HC_W'(i + 3)) base_d[i] = IM_Q[ADDR_W-1:0];
                end
                if (hdr_cnt_q == HC_LAST) begin
                    state_d     = S_COPY;
                    hdr_cnt_d   = '0;
                    idx_d       = 4'd0;
                    mode_d      = 1'b0;
                    phase_d     = 1'b0;
                    col_d       = '0;
                    row_d       = '0;
                    rows_done_d = '0;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + HC_W'(1);
                end
            end
            S_COPY: begin
                if (!phase_q) begin
                    IM_A    = src_base + pix_off;
                    phase_d = 1'b1;
                end else begin
                    IM_A    = fb_q + pix_off;
                    IM_WEN  = 1'b0;
                    IM_D    = IM_Q;
                    im_d_d  = IM_Q;
                    phase_d = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (rows_done_q == ROW_LAST) begin
                            state_d      = S_WAIT;
                            frame_done_d = 1'b1;
                            sec_d        = '0;
                            hold_d       = '0;
                        end else begin
                            rows_done_d = rows_done_q + ROW_W'(1);
                            row_d       = next_row;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (sec_q == SEC_LAST) begin
                    sec_d = '0;
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (stop_req_q) begin
                            state_d    = S_IDLE;
                            stop_req_d = 1'b0;
                        end else begin
                            state_d     = S_COPY;
                            idx_d       = (idx_q == n_q - 4'd1) ? 4'd0 : idx_q + 4'd1;
                            mode_d      = trans_mode;
                            phase_d     = 1'b0;
                            col_d       = '0;
                            row_d       = '0;
                            rows_done_d = '0;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hdr_cnt_q    <= '0;
            fb_q         <= '0;
            n_q          <= '0;
            for (int i = 0; i < MAX_PHOTOS; i++) base_q[i] <= '0;
            idx_q        <= '0;
            mode_q       <= 1'b0;
            phase_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            rows_done_q  <= '0;
            sec_q        <= '0;
            hold_q       <= '0;
            stop_req_q   <= 1'b0;
            im_d_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            fb_q         <= fb_d;
            n_q          <= n_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            rows_done_q  <= rows_done_d;
            sec_q        <= sec_d;
            hold_q       <= hold_d;
            stop_req_q   <= stop_req_d;
            im_d_q       <= im_d_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign photo_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dpa_photo_sequencer.sv
// Bench for dpa_photo_sequencer: random image data and transition modes against a cycle-timeline model.
// Latency: expectations placed on absolute cycles derived from the header/copy/hold lengths.
// Backpressure: none; the bench acts as a zero-wait single-port memory.
module tb_dpa_photo_sequencer;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 24;
    localparam int MAX_PHOTOS = 4;
    localparam int IMG_W      = 4;
    localparam int IMG_H      = 2;
    localparam int TPS        = 5;
    localparam int HOLD       = 2;
    localparam int NPIX       = IMG_W * IMG_H;
    localparam int COPY_LEN   = 2 * NPIX;
    localparam int WAIT_LEN   = TPS * HOLD;
    localparam int PERIOD     = COPY_LEN + WAIT_LEN;
    localparam int HDR_LEN    = 3 + MAX_PHOTOS;
    localparam int TR_N       = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              trans_mode;
    logic [ADDR_W-1:0] IM_A;
    logic [DATA_W-1:0] IM_Q = '0;
    logic [DATA_W-1:0] IM_D;
    logic              IM_WEN;
    logic              busy;
    logic [3:0]        photo_idx;
    logic              frame_done;

    logic [23:0] mem [0:4095];
    int          rd_addr = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] tr_a    [TR_N];
    logic [31:0] tr_d    [TR_N];
    logic [31:0] tr_wen  [TR_N];
    logic [31:0] tr_busy [TR_N];
    logic [31:0] tr_idx  [TR_N];
    logic [31:0] tr_fd   [TR_N];

    dpa_photo_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PHOTOS(MAX_PHOTOS),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .TICKS_PER_SEC(TPS), .HOLD_SEC(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .trans_mode(trans_mode),
        .IM_A(IM_A), .IM_Q(IM_Q), .IM_D(IM_D), .IM_WEN(IM_WEN),
        .busy(busy), .photo_idx(photo_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Cycle counter and memory read port (data valid the cycle after the address).
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        IM_Q <= mem[rd_addr];
    end

    // Mid-cycle observation: trace every output, latch the read address, commit writes.
    always @(negedge clk) begin
        if (cyc < TR_N) begin
            tr_a[cyc]    = 32'(IM_A);
            tr_d[cyc]    = 32'(IM_D);
            tr_wen[cyc]  = 32'(IM_WEN);
            tr_busy[cyc] = 32'(busy);
            tr_idx[cyc]  = 32'(photo_idx);
            tr_fd[cyc]   = 32'(frame_done);
        end
        rd_addr = int'(IM_A[11:0]);
        if (IM_WEN === 1'b0) mem[IM_A[11:0]] = IM_D;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Row visited at a given step: direct is in order, interlaced is all even rows then all odd rows.
    function automatic int row_at(input int step, input int il);
        int ne;
        ne = (IMG_H + 1) / 2;
        if (il == 0) return step;
        if (step < ne) return 2 * step;
        return 2 * (step - ne) + 1;
    endfunction

    task automatic check_frame(input int cs, input int p, input int il, input int fb, input int base);
        int off;
        int prev_off;
        int bad;
        prev_off = 0;
        for (int k = 0; k < NPIX; k++) begin
            off = row_at(k / IMG_W, il) * IMG_W + (k % IMG_W);
            chk("rd_addr", tr_a[cs + 2*k], 32'(base + off));
            chk("rd_wen", tr_wen[cs + 2*k], 32'd1);
            if (k > 0) chk("imd_hold_rd", tr_d[cs + 2*k], 32'(mem[base + prev_off]));
            chk("wr_addr", tr_a[cs + 2*k + 1], 32'(fb + off));
            chk("wr_wen", tr_wen[cs + 2*k + 1], 32'd0);
            chk("wr_data", tr_d[cs + 2*k + 1], 32'(mem[base + off]));
            prev_off = off;
        end
        chk("copy_idx", tr_idx[cs + 1], 32'(p));
        chk("copy_busy", tr_busy[cs], 32'd1);
        chk("fd_before", tr_fd[cs + COPY_LEN - 1], 32'd0);
        chk("frame_done", tr_fd[cs + COPY_LEN], 32'd1);
        chk("fd_after", tr_fd[cs + COPY_LEN + 1], 32'd0);
        chk("wait_idx", tr_idx[cs + COPY_LEN + 4], 32'(p));
        chk("wait_imd_hold", tr_d[cs + COPY_LEN + 4], 32'(mem[base + prev_off]));
        bad = 0;
        for (int c = cs + COPY_LEN; c < cs + PERIOD; c++) begin
            if (tr_wen[c] !== 32'd1 || tr_busy[c] !== 32'd1) bad++;
        end
        chk("wait_quiet", 32'(bad), 32'd0);
    endtask

    task automatic scenario(input int fb, input int num_lo, input int b0, input int b1,
                            input int b2, input int b3, input int nframes, input bit stop_with_start);
        int          bases [4];
        int          modes [8];
        int          n;
        int          t0;
        int          cs;
        int          last_cs;
        logic [23:0] num_word;
        bases[0] = b0; bases[1] = b1; bases[2] = b2; bases[3] = b3;
        num_word = {20'($urandom), 4'(num_lo)};
        mem[0] = 24'(fb);
        mem[1] = num_word;
        for (int i = 0; i < 4; i++) mem[2 + i] = 24'(bases[i]);
        n = num_lo;
        if (n == 0) n = 1;
        if (n > MAX_PHOTOS) n = MAX_PHOTOS;
        modes[0] = 0;
        modes[1] = 1;
        for (int f = 2; f < 8; f++) modes[f] = int'($urandom_range(0, 1));

        trans_mode = 1'b1;
        t0 = cyc;
        start = 1'b1;
        stop  = stop_with_start;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;

        for (int f = 0; f < nframes; f++) begin
            cs = t0 + 1 + HDR_LEN + PERIOD * f;
            wait_until(cs + 4);
            if (f + 1 < nframes) trans_mode = modes[f + 1][0];
            if (f == nframes - 1) begin
                wait_until(cs + 5);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
            end
            if (f == 1) begin
                wait_until(cs + 7);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        last_cs = t0 + 1 + HDR_LEN + PERIOD * (nframes - 1);
        wait_until(last_cs + PERIOD + 3);

        chk("busy_before_start", tr_busy[t0], 32'd0);
        chk("busy_after_start", tr_busy[t0 + 1], 32'd1);
        for (int c = 0; c < 2 + MAX_PHOTOS; c++) begin
            chk("hdr_addr", tr_a[t0 + 1 + c], 32'(c));
            chk("hdr_wen", tr_wen[t0 + 1 + c], 32'd1);
        end
        for (int f = 0; f < nframes; f++) begin
            cs = t0 + 1 + HDR_LEN + PERIOD * f;
            check_frame(cs, f % n, (f == 0) ? 0 : modes[f], fb, bases[f % n]);
        end
        chk("end_wait_busy", tr_busy[last_cs + PERIOD - 1], 32'd1);
        chk("idle_busy", tr_busy[last_cs + PERIOD], 32'd0);
        chk("idle_addr", tr_a[last_cs + PERIOD], 32'd0);
        chk("idle_wen", tr_wen[last_cs + PERIOD], 32'd1);
        chk("idle_stays", tr_busy[last_cs + PERIOD + 2], 32'd0);
    endtask

    initial begin
        int t0;
        int t_rel;
        int bad;
        reset = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        trans_mode = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = (a >= 512) ? 24'($urandom) : 24'h0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_addr", 32'(IM_A), 32'd0);
        chk("rst_data", 32'(IM_D), 32'd0);
        chk("rst_wen", 32'(IM_WEN), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(photo_idx), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Two photos: direct first frame, interlaced photo 1, wrap back to photo 0, start while busy.
        scenario(32'h100, 2, 32'h200, 32'h300, 32'h400, 32'h500, 4, 1'b0);
        // Header count 0 shows photo 0 only.
        scenario(32'h180, 0, 32'h300, 32'h200, 32'h500, 32'h400, 3, 1'b0);
        // Header count 9 clamps to 4 slots; a stop coinciding with start is discarded.
        scenario(32'h140, 9, 32'h200, 32'h300, 32'h400, 32'h500, 5, 1'b1);

        // Reset during a write cycle of photo 1.
        mem[0] = 24'h100;
        mem[1] = {20'($urandom), 4'd2};
        mem[2] = 24'h200;
        mem[3] = 24'h300;
        trans_mode = 1'b0;
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 1 + HDR_LEN + PERIOD + 3);
        chk("pre_reset_wen", 32'(IM_WEN), 32'd0);
        chk("pre_reset_idx", 32'(photo_idx), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("arst_wen", 32'(IM_WEN), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", 32'(IM_A), 32'd0);
        chk("arst_data", 32'(IM_D), 32'd0);
        chk("arst_idx", 32'(photo_idx), 32'd0);
        chk("arst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        t_rel = cyc;
        wait_until(t_rel + 41);
        bad = 0;
        for (int c = t_rel; c < t_rel + 40; c++) begin
            if (tr_wen[c] !== 32'd1 || tr_busy[c] !== 32'd0) bad++;
        end
        chk("no_write_after_reset", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
